// File: rtl/dp_chain_bist_if.sv
// Bus bundle for dp_chain_bist: functional word path plus BIST control/status.
// master drives inputs (in_*, bist_start/abort); slave is the chain.
interface dp_chain_bist_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             bist_start;
  logic             bist_abort;
  logic             bist_busy;
  logic             bist_done;
  logic [WIDTH-1:0] bist_sig;

  modport master (
    output in_data, in_valid, bist_start, bist_abort,
    input  out_data, out_valid, bist_busy, bist_done, bist_sig
  );

  modport slave (
    input  in_data, in_valid, bist_start, bist_abort,
    output out_data, out_valid, bist_busy, bist_done, bist_sig
  );
endinterface

// File: rtl/dp_chain_bist.sv
// Register/mix chain of NUM_SEG*DATA_DEPTH stages with LFSR BIST and compactor.
// Ports: clk, rst (async active-low), bus (slave: in_*, out_*, bist_*).
module dp_chain_bist #(
  parameter int WIDTH      = 8,
  parameter int DATA_DEPTH = 10,
  parameter int COMB_DEPTH = 3,
  parameter int NUM_SEG    = 3,
  parameter int BIST_LEN   = 256,
  parameter logic [WIDTH-1:0] LFSR_SEED =
    {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
)(
  input logic      clk,
  input logic      rst,
  dp_chain_bist_if.slave bus
);

  localparam int L  = NUM_SEG * DATA_DEPTH;
  localparam int CW = $clog2(BIST_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(BIST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data [L];
  logic [L-1:0]     r_vld;
  logic [L-1:0]     r_tag;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_sig;
  logic [CW-1:0]    r_cnt_in;
  logic [CW-1:0]    r_cnt_out;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_src_d;
  logic             w_src_v;
  logic             w_src_t;
  logic             w_cmp;
  logic             w_start;
  logic             w_abort;

  function automatic logic [WIDTH-1:0] f_rotl(
    input logic [WIDTH-1:0] x
  );
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] f_mixn(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] v;
    v = x;
    for (int i = 0; i < COMB_DEPTH; i++)
      v = f_rotl(v) ^ v;
    return v;
  endfunction

  assign w_start = bus.bist_start;
  assign w_abort = bus.bist_abort;
  assign w_cmp   = r_vld[L-1] & r_tag[L-1];

  always_comb begin
    w_src_d = '0;
    w_src_v = 1'b0;
    w_src_t = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_src_d = r_lfsr;
        w_src_v = 1'b1;
        w_src_t = 1'b1;
      end
      S_DRAIN: begin
        w_src_d = '0;
      end
      default: begin
        w_src_d = bus.in_data;
        w_src_v = bus.in_valid;
      end
    endcase
  end

  // Data and valid always shift; abort strips every tag in flight so
  // leftover BIST words drain out as plain untagged traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++)
        r_data[i] <= '0;
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_data[0] <= f_mixn(w_src_d);
      r_vld[0]  <= w_src_v;
      r_tag[0]  <= w_src_t & ~w_abort;
      for (int i = 1; i < L; i++) begin
        r_data[i] <= f_mixn(r_data[i-1]);
        r_vld[i]  <= r_vld[i-1];
        r_tag[i]  <= r_tag[i-1] & ~w_abort;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_sig     <= '0;
      r_cnt_in  <= '0;
      r_cnt_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_cmp) begin
        r_sig     <= f_rotl(r_sig) ^ r_data[L-1];
        r_cnt_out <= r_cnt_out + 1'b1;
      end
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state   <= S_RUN;
            r_lfsr    <= LFSR_SEED;
            r_sig     <= '0;
            r_cnt_in  <= '0;
            r_cnt_out <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        S_RUN: begin
          r_lfsr <= (r_lfsr >> 1) ^
                    (r_lfsr[0] ? LFSR_TAPS : '0);
          r_cnt_in <= r_cnt_in + 1'b1;
          if (r_cnt_in == LAST)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Finish on the cycle the last tagged word is folded in.
          if (w_cmp && r_cnt_out == LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data  = r_data[L-1];
  assign bus.out_valid = r_vld[L-1];
  assign bus.bist_busy = r_busy;
  assign bus.bist_done = r_done;
  assign bus.bist_sig  = r_sig;

endmodule

// File: tb/tb_dp_chain_bist.sv
// Testbench for dp_chain_bist: vector tables, directed BIST sequences,
// and a randomized run against a delay-line reference model.
module tb_dp_chain_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  int n_cmp = 0;
  int n_bad = 0;

  dp_chain_bist_if #(.WIDTH(8)) ifa ();
  dp_chain_bist_if #(.WIDTH(8)) ifb ();
  dp_chain_bist_if #(.WIDTH(6)) ifc ();

  dp_chain_bist #(
    .WIDTH(8), .DATA_DEPTH(2), .COMB_DEPTH(0), .NUM_SEG(3),
    .BIST_LEN(2), .LFSR_SEED(8'h01), .LFSR_TAPS(8'hB8)
  ) u_a (.clk(clk), .rst(rst_a), .bus(ifa));

  dp_chain_bist #(
    .WIDTH(8), .DATA_DEPTH(2), .COMB_DEPTH(1), .NUM_SEG(3),
    .BIST_LEN(2), .LFSR_SEED(8'h01), .LFSR_TAPS(8'hB8)
  ) u_b (.clk(clk), .rst(rst_b), .bus(ifb));

  localparam int CL  = 6;
  localparam int CBL = 20;
  dp_chain_bist #(
    .WIDTH(6), .DATA_DEPTH(3), .COMB_DEPTH(2), .NUM_SEG(2),
    .BIST_LEN(CBL), .LFSR_SEED(6'h05), .LFSR_TAPS(6'h30)
  ) u_c (.clk(clk), .rst(rst_a), .bus(ifc));

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ov;
    logic [7:0] od;
  } vec_t;

  vec_t tv [30];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mixw(input logic [31:0] x,
                                       input int w,
                                       input int n);
    logic [31:0] m;
    logic [31:0] v;
    m = (32'h1 << w) - 1;
    v = x & m;
    for (int i = 0; i < n; i++)
      v = (((v << 1) | (v >> (w - 1))) ^ v) & m;
    return v;
  endfunction

  logic       hv [256];
  logic       ht [256];
  logic [5:0] hd [256];

  initial begin
    ifa.in_data = '0; ifa.in_valid = 0;
    ifa.bist_start = 0; ifa.bist_abort = 0;
    ifb.in_data = '0; ifb.in_valid = 0;
    ifb.bist_start = 0; ifb.bist_abort = 0;
    ifc.in_data = '0; ifc.in_valid = 0;
    ifc.bist_start = 0; ifc.bist_abort = 0;
    rst_a = 0;
    rst_b = 0;
    #12;
    chk("rst_a_ov", ifa.out_valid, 0);
    chk("rst_a_od", ifa.out_data, 0);
    chk("rst_a_busy", ifa.bist_busy, 0);
    chk("rst_a_done", ifa.bist_done, 0);
    chk("rst_a_sig", ifa.bist_sig, 0);
    chk("rst_c_sig", ifc.bist_sig, 0);
    chk("rst_b_ov", ifb.out_valid, 0);
    #10;
    rst_a = 1;
    rst_b = 1;
    tick();

    // Latency and identity vectors on instance A
    tv[0] = '{1'b1, 8'hA5, 1'b0, 8'h00};
    for (int k = 1; k < 30; k++) tv[k] = '{1'b0, 8'h00, 1'b0, 8'h00};
    tv[6] = '{1'b0, 8'h00, 1'b1, 8'hA5};
    for (int k = 8; k < 24; k++) begin
      tv[k].iv = 1'b1;
      tv[k].id = 8'(k - 7);
    end
    for (int k = 14; k < 30; k++) begin
      tv[k].ov = 1'b1;
      tv[k].od = 8'(k - 13);
    end
    for (int k = 0; k < 30; k++) begin
      ifa.in_valid = tv[k].iv;
      ifa.in_data  = tv[k].id;
      chk($sformatf("vec%0d_ov", k), ifa.out_valid, tv[k].ov);
      chk($sformatf("vec%0d_od", k), ifa.out_data, tv[k].od);
      tick();
    end
    ifa.in_valid = 0;
    ifa.in_data  = '0;

    // BIST run, BIST_LEN=2
    for (int c = 0; c < 13; c++) begin
      ifa.bist_start = (c == 0);
      chk($sformatf("bist_busy%0d", c), ifa.bist_busy,
          (c >= 1 && c <= 8));
      chk($sformatf("bist_done%0d", c), ifa.bist_done, (c >= 9));
      if (c >= 9) chk("bist_sig", ifa.bist_sig, 8'hBA);
      if (c == 7) chk("bist_w0", ifa.out_data, 8'h01);
      if (c == 8) chk("bist_w1", ifa.out_data, 8'hB8);
      tick();
    end
    ifa.bist_start = 0;

    // Isolation: functional words in flight when BIST restarts from DONE
    for (int c = 0; c < 14; c++) begin
      ifa.in_valid   = (c < 2);
      ifa.in_data    = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h00;
      ifa.bist_start = (c == 2);
      if (c == 6) begin
        chk("iso_ov0", ifa.out_valid, 1);
        chk("iso_od0", ifa.out_data, 8'h11);
      end
      if (c == 7) chk("iso_od1", ifa.out_data, 8'h22);
      if (c == 3) chk("iso_sig0", ifa.bist_sig, 0);
      if (c == 3) chk("iso_busy", ifa.bist_busy, 1);
      if (c == 9) chk("iso_w0", ifa.out_data, 8'h01);
      if (c == 10) chk("iso_done_early", ifa.bist_done, 0);
      if (c >= 11) begin
        chk("iso_done", ifa.bist_done, 1);
        chk("iso_sig", ifa.bist_sig, 8'hBA);
      end
      tick();
    end
    ifa.in_valid = 0;
    ifa.bist_start = 0;

    // Abort in cycle 4
    for (int c = 0; c < 11; c++) begin
      ifa.bist_start = (c == 0);
      ifa.bist_abort = (c == 4);
      if (c == 4) chk("abt_busy4", ifa.bist_busy, 1);
      if (c == 5) begin
        chk("abt_busy5", ifa.bist_busy, 0);
        chk("abt_done5", ifa.bist_done, 0);
        chk("abt_sig5", ifa.bist_sig, 0);
      end
      if (c == 7) begin
        chk("abt_ov7", ifa.out_valid, 1);
        chk("abt_od7", ifa.out_data, 8'h01);
      end
      if (c == 10) begin
        chk("abt_sig10", ifa.bist_sig, 0);
        chk("abt_done10", ifa.bist_done, 0);
      end
      tick();
    end

    // Restart, then simultaneous start+abort
    for (int c = 0; c < 15; c++) begin
      ifa.bist_start = (c == 0) || (c == 12);
      ifa.bist_abort = (c == 12);
      if (c >= 9 && c <= 12) begin
        chk("rst_done", ifa.bist_done, 1);
        chk("rst_sig", ifa.bist_sig, 8'hBA);
      end
      if (c >= 13) begin
        chk("sa_busy", ifa.bist_busy, 0);
        chk("sa_done", ifa.bist_done, 0);
        chk("sa_sig", ifa.bist_sig, 0);
      end
      tick();
    end
    ifa.bist_start = 0;
    ifa.bist_abort = 0;

    // Mix on instance B, COMB_DEPTH=1
    for (int c = 0; c < 8; c++) begin
      ifb.in_valid = (c == 0);
      ifb.in_data  = (c == 0) ? 8'h01 : 8'h00;
      if (c == 6) begin
        chk("mix_ov", ifb.out_valid, 1);
        chk("mix_od", ifb.out_data, 8'h55);
      end
      if (c == 7) chk("mix_ov7", ifb.out_valid, 0);
      tick();
    end

    // Asynchronous reset mid-flight on B
    for (int c = 0; c < 9; c++) begin
      ifb.in_valid = 1;
      ifb.in_data  = 8'(8'h40 + c);
      if (c == 8) begin
        chk("pre_rst_ov", ifb.out_valid, 1);
        chk("pre_rst_od", ifb.out_data, mixw(32'h42, 8, 6));
      end
      if (c < 8) tick();
    end
    #2;
    rst_b = 0;
    #1;
    chk("arst_ov", ifb.out_valid, 0);
    chk("arst_od", ifb.out_data, 0);
    ifb.in_valid = 0;
    ifb.in_data  = '0;
    #3;
    rst_b = 1;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk("post_rst_ov", ifb.out_valid, 0);
      chk("post_rst_od", ifb.out_data, 0);
      tick();
    end

    // Randomized run on instance C against a delay-line model
    begin
      int s;
      int tot;
      logic [5:0] mlfsr;
      logic [5:0] msig;
      logic       ev;
      logic       et;
      logic [5:0] ed;
      logic       rd;
      s     = 100;
      tot   = s + CBL + CL + 12;
      mlfsr = 6'h05;
      msig  = '0;
      for (int c = 0; c < tot; c++) begin
        logic       iv;
        logic [5:0] id;
        iv = 1'($urandom);
        id = 6'($urandom);
        rd = (c >= s + 1) && (c <= s + CBL + CL);
        ifc.in_valid   = iv;
        ifc.in_data    = id;
        ifc.bist_start = (c == s) || (rd && $urandom_range(0, 3) == 0);
        if (c == s) mlfsr = 6'h05;
        if (c >= s + 1 && c <= s + CBL) begin
          hv[c] = 1'b1;
          ht[c] = 1'b1;
          hd[c] = mlfsr;
          mlfsr = (mlfsr >> 1) ^ (mlfsr[0] ? 6'h30 : 6'h00);
        end else if (rd) begin
          hv[c] = 1'b0;
          ht[c] = 1'b0;
          hd[c] = '0;
        end else begin
          hv[c] = iv;
          ht[c] = 1'b0;
          hd[c] = id;
        end
        if (c >= CL) begin
          ev = hv[c-CL];
          et = ht[c-CL];
          ed = 6'(mixw(32'(hd[c-CL]), 6, 12));
        end else begin
          ev = 0;
          et = 0;
          ed = '0;
        end
        chk($sformatf("rnd_ov%0d", c), ifc.out_valid, ev);
        chk($sformatf("rnd_od%0d", c), ifc.out_data, ed);
        chk($sformatf("rnd_busy%0d", c), ifc.bist_busy, rd);
        chk($sformatf("rnd_done%0d", c), ifc.bist_done,
            (c >= s + CBL + CL + 1));
        chk($sformatf("rnd_sig%0d", c), ifc.bist_sig, msig);
        if (ev && et)
          msig = {msig[4:0], msig[5]} ^ ed;
        if (c == s) msig = '0;
        tick();
      end
      ifc.bist_start = 0;
      ifc.in_valid   = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
